sliding_window_buffer: RTL and testbench
========================================

// Module: sliding_window_buffer
// PURPOSE
//  Parametrised successor to the fixed 5x5 buffer_window. Takes a raster stream of grayscale pixels from the
//  grayscale stage and keeps K-1 line buffers of IMG_WIDTH pixels. It emits a KxK window for every pixel
//  position where the window lies fully inside the image. Sits between grayscale and edge_detection_core,
//  with valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_W      8    pixel width in bits
//  K           5    window edge; odd, 3..7
//  IMG_WIDTH   640  pixels per line; >= K
//  IMG_HEIGHT  480  lines per frame; >= K
// PORTS
//  clk              in   1           system clock, rising edge
//  n_rst            in   1           asynchronous active-low reset
//  i_clear          in   1           synchronous frame abort; restarts at pixel (0,0)
//  i_pixel_valid    in   1           i_pixel holds a valid raster-order pixel
//  i_pixel          in   DATA_W      pixel value
//  o_pixel_ready    out  1           block accepts i_pixel this cycle
//  o_window         out  K*K*DATA_W  window; element r*K+c at [DATA_W*(r*K+c) +: DATA_W]
//  o_window_valid   out  1           o_window valid
//  i_window_ready   in   1           downstream consumes o_window this cycle
//  o_primed         out  1           row counter >= K-1 (line buffers hold K-1 full lines)
//  o_frame_done     out  1           one-cycle pulse after the frame's last pixel is accepted
// BEHAVIOUR
//  - Reset (n_rst=0, asynchronous): outputs o_window, o_window_valid, o_primed and o_frame_done go to 0.
//    Row/col counters and window registers also go to 0. Line-buffer RAM is not reset; its contents are don't-care.
//  - o_pixel_ready = !i_clear && (!o_window_valid || i_window_ready). This is combinational, with no skid buffer.
//  - Accept = i_pixel_valid && o_pixel_ready. On accept, in one cycle:
//      * Window column for col = {line buffers 0..K-2 at col, i_pixel} shifts into window column K-1.
//        Existing window columns shift left by one.
//      * Line buffer j takes line buffer j+1 at col. Line buffer K-2 takes i_pixel.
//      * col increments. At IMG_WIDTH-1 it wraps to 0 and row increments.
//      * At row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, both counters go to 0 and o_frame_done pulses next cycle.
//  - Window layout: r=0 is the oldest line (top), c=0 is the leftmost column.
//    Element 0 is top-left. Element K*K-1 is the pixel just accepted.
//  - o_window_valid is set on the edge after an accept whose pre-increment row >= K-1 and col >= K-1.
//    Latency is 1 cycle from the accepting edge.
//  - o_window_valid clears when i_window_ready=1 and there is no qualifying accept in the same cycle.
//    A consume and a qualifying accept in the same cycle keep it at 1 with the new window.
//  - Stall: while o_window_valid=1 and i_window_ready=0, o_pixel_ready=0.
//    o_window and all state hold bit-stable.
//  - Windows per frame = (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1). Positions with col<K-1 at a line start are
//    never flagged valid, even though the window registers hold wrapped data there.
//  - i_clear (sync): next cycle row=col=0 and o_window_valid=0. o_primed=0 and o_frame_done is suppressed.
//    No pixel is accepted while i_clear=1, so a pixel presented together with clear is not taken.
//    Line-buffer contents are left stale; no window uses them before they are overwritten.
//  - Reset mid-frame: same end state as clear, asynchronously.
//  - Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). Wrap uses compare-to-max, not overflow.
//  - No arithmetic on pixel data; pixel values pass through unmodified.
// TESTING  (K=3, IMG_WIDTH=4, IMG_HEIGHT=4, DATA_W=8, pixel n = value n, ready always high unless stated)
//  1. Stream 0..15 back-to-back.
//     -> o_window_valid after pixels 10,11,14,15 only, with windows {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11},
//        {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}.
//     -> o_frame_done is high exactly one cycle, the cycle after pixel 15 is accepted.
//  2. Same stream, i_window_ready low for 5 cycles after window {0,..,10}.
//     -> o_pixel_ready=0 and o_window is stable for those 5 cycles.
//     -> Pixel 11 is accepted on the first ready cycle and the sequence matches test 1.
//  3. Random i_pixel_valid gaps (~50%) and random i_window_ready.
//     -> Window sequence and count (4) are identical to test 1. No window is duplicated or dropped.
//  4. Two frames back-to-back, second frame values 100..115.
//     -> The first window of frame 2 is {100,101,102,104,105,106,108,109,110}, with no frame-1 data.
//  5. i_clear asserted together with pixel 9 valid, then restream 0..15.
//     -> Pixel 9 is not accepted and o_window_valid=0.
//     -> The output sequence then equals test 1.
//  6. n_rst pulsed low asynchronously after pixel 10.
//     -> All outputs are 0 immediately.
//     -> Restreaming 0..15 reproduces test 1.

Source files
------------

// File: rtl/sliding_window_buffer.sv
// -----------------------------------------------------------------------------
// sliding_window_buffer
//   Turns a raster-order pixel stream into a KxK neighbourhood window for every
//   pixel position where the window lies entirely inside the image. K-1 line
//   buffers hold the previous lines. Both sides use a valid/ready handshake.
//
// Ports
//   clk             system clock, rising edge
//   n_rst           asynchronous active-low reset
//   i_clear         synchronous frame abort, restarts at pixel (0,0)
//   i_pixel_valid   i_pixel carries a raster-order pixel
//   i_pixel         pixel value
//   o_pixel_ready   pixel is accepted this cycle when valid
//   o_window        KxK window, element r*K+c at [DATA_W*(r*K+c) +: DATA_W]
//                   (r=0 oldest line, c=0 leftmost, last element newest pixel)
//   o_window_valid  o_window holds a fully in-image window
//   i_window_ready  downstream consumes o_window this cycle
//   o_primed        line buffers hold K-1 complete lines
//   o_frame_done    one-cycle pulse after the last pixel of a frame is taken
// -----------------------------------------------------------------------------
module sliding_window_buffer #(
    parameter int DATA_W     = 8,
    parameter int K          = 5,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_clear,
    input  logic                  i_pixel_valid,
    input  logic [DATA_W-1:0]     i_pixel,
    output logic                  o_pixel_ready,
    output logic [K*K*DATA_W-1:0] o_window,
    output logic                  o_window_valid,
    input  logic                  i_window_ready,
    output logic                  o_primed,
    output logic                  o_frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_MAX   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    // Line buffer 0 holds the oldest line, K-2 the most recent complete line.
    logic [DATA_W-1:0] r_line [K-1][IMG_WIDTH];
    logic [DATA_W-1:0] r_win  [K][K];

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_window_valid;
    logic          r_frame_done;

    logic w_accept;
    logic w_last_col;
    logic w_last_row;
    logic w_qualify;

    assign o_pixel_ready = !i_clear && (!r_window_valid || i_window_ready);
    assign w_accept      = i_pixel_valid && o_pixel_ready;
    assign w_last_col    = (r_col == COL_MAX);
    assign w_last_row    = (r_row == ROW_MAX);
    // Only positions whose window lies fully inside the image are flagged;
    // the window registers still shift at line starts but hold wrapped data.
    assign w_qualify     = w_accept && (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);

    assign o_window_valid = r_window_valid;
    assign o_frame_done   = r_frame_done;
    assign o_primed       = (r_row >= ROW_FIRST);

    always_comb begin
        o_window = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                o_window[DATA_W*(r*K+c) +: DATA_W] = r_win[r][c];
            end
        end
    end

    // Line-buffer storage carries no reset: stale contents are always
    // overwritten before any flagged window can reference them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int j = 0; j < K-2; j++) begin
                r_line[j][r_col] <= r_line[j+1][r_col];
            end
            r_line[K-2][r_col] <= i_pixel;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col          <= '0;
            r_row          <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (i_clear) begin
            r_col          <= '0;
            r_row          <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last_col && w_last_row;

            if (w_qualify) begin
                r_window_valid <= 1'b1;
            end else if (i_window_ready) begin
                r_window_valid <= 1'b0;
            end

            if (w_accept) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K-1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                end
                for (int r = 0; r < K-1; r++) begin
                    r_win[r][K-1] <= r_line[r][r_col];
                end
                r_win[K-1][K-1] <= i_pixel;

                if (w_last_col) begin
                    r_col <= '0;
                    if (w_last_row) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_buffer.sv
module tb_sliding_window_buffer;

    localparam int DATA_W = 8;
    localparam int K      = 3;
    localparam int W      = 4;
    localparam int H      = 4;
    localparam int WW     = K*K*DATA_W;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              i_clear;
    logic              i_pixel_valid;
    logic [DATA_W-1:0] i_pixel;
    logic              o_pixel_ready;
    logic [WW-1:0]     o_window;
    logic              o_window_valid;
    logic              i_window_ready;
    logic              o_primed;
    logic              o_frame_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit rand_mode = 0;
    logic [WW-1:0] win_q [$];

    sliding_window_buffer #(
        .DATA_W(DATA_W), .K(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .i_clear(i_clear),
        .i_pixel_valid(i_pixel_valid),
        .i_pixel(i_pixel),
        .o_pixel_ready(o_pixel_ready),
        .o_window(o_window),
        .o_window_valid(o_window_valid),
        .i_window_ready(i_window_ready),
        .o_primed(o_primed),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    // Record every window handed over and every frame-done pulse.
    always @(negedge clk) begin
        if (n_rst && o_window_valid && i_window_ready) win_q.push_back(o_window);
        if (n_rst && o_frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window at top-left position (pos/2, pos%2) of a frame whose pixel n = base+n.
    function automatic logic [WW-1:0] exp_win(input int base, input int pos);
        logic [WW-1:0] w;
        int wr, wc;
        wr = pos / 2;
        wc = pos % 2;
        w  = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[DATA_W*(r*K+c) +: DATA_W] = DATA_W'(base + (wr+r)*W + wc + c);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) i_window_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] v, output int n);
        logic acc;
        n   = 0;
        acc = 1'b0;
        if (rand_mode) repeat ($urandom_range(0, 1)) tick();
        i_pixel       = v;
        i_pixel_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = o_pixel_ready;
            tick();
            n++;
        end
        i_pixel_valid = 1'b0;
        chk("pixel_accepted", WW'(acc), WW'(1));
    endtask

    task automatic stream(input int base, input int first, input int last);
        int n;
        for (int i = first; i <= last; i++) send(8'(base + i), n);
    endtask

    task automatic drain();
        rand_mode      = 0;
        i_window_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic check_windows(input string tag, input int b0, input int b1, input int n);
        logic [WW-1:0] obs;
        chk({tag, "_count"}, WW'(win_q.size()), WW'(n));
        for (int i = 0; i < n; i++) begin
            obs = (i < win_q.size()) ? win_q[i] : {WW{1'bx}};
            chk(tag, obs, exp_win((i < 4) ? b0 : b1, i % 4));
        end
    endtask

    task automatic restart_capture();
        win_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        int n;
        n_rst          = 1'b0;
        i_clear        = 1'b0;
        i_pixel_valid  = 1'b0;
        i_pixel        = '0;
        i_window_ready = 1'b1;
        #1;
        chk("rst_window", o_window, '0);
        chk("rst_valid", WW'(o_window_valid), '0);
        chk("rst_primed", WW'(o_primed), '0);
        chk("rst_done", WW'(o_frame_done), '0);
        chk("rst_pixel_ready", WW'(o_pixel_ready), WW'(1));
        repeat (2) tick();
        n_rst = 1'b1;
        tick();

        // 1: back-to-back stream with per-pixel status checks
        restart_capture();
        for (int i = 0; i < 16; i++) begin
            send(8'(i), n);
            chk("t1_valid", WW'(o_window_valid), WW'((i / W >= K-1) && (i % W >= K-1)));
            chk("t1_primed", WW'(o_primed), WW'((i >= 2*W-1) && (i < W*H-1)));
            chk("t1_done", WW'(o_frame_done), WW'(i == W*H-1));
        end
        tick();
        chk("t1_done_pulse_end", WW'(o_frame_done), '0);
        drain();
        check_windows("t1_win", 0, 0, 4);
        chk("t1_done_count", WW'(done_cnt), WW'(1));

        // 2: downstream stall after the first window
        restart_capture();
        stream(0, 0, 10);
        i_window_ready = 1'b0;
        i_pixel        = 8'd11;
        i_pixel_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t2_stall_ready", WW'(o_pixel_ready), '0);
            chk("t2_stall_valid", WW'(o_window_valid), WW'(1));
            chk("t2_stall_window", o_window, exp_win(0, 0));
            tick();
        end
        i_window_ready = 1'b1;
        send(8'd11, n);
        chk("t2_first_ready_accept", WW'(n), WW'(1));
        stream(0, 12, 15);
        drain();
        check_windows("t2_win", 0, 0, 4);

        // 3: random source gaps and random downstream ready
        restart_capture();
        rand_mode = 1;
        stream(0, 0, 15);
        drain();
        check_windows("t3_win", 0, 0, 4);
        chk("t3_done_count", WW'(done_cnt), WW'(1));

        // 4: two frames back to back
        restart_capture();
        stream(0, 0, 15);
        stream(100, 0, 15);
        drain();
        check_windows("t4_win", 0, 100, 8);
        chk("t4_done_count", WW'(done_cnt), WW'(2));

        // 5: clear together with pixel 9
        restart_capture();
        stream(0, 0, 8);
        chk("t5_primed_before", WW'(o_primed), WW'(1));
        i_clear       = 1'b1;
        i_pixel       = 8'd9;
        i_pixel_valid = 1'b1;
        @(negedge clk);
        chk("t5_clear_ready", WW'(o_pixel_ready), '0);
        tick();
        i_clear       = 1'b0;
        i_pixel_valid = 1'b0;
        chk("t5_valid", WW'(o_window_valid), '0);
        chk("t5_primed", WW'(o_primed), '0);
        chk("t5_done", WW'(o_frame_done), '0);
        stream(0, 0, 15);
        drain();
        check_windows("t5_win", 0, 0, 4);
        chk("t5_done_count", WW'(done_cnt), WW'(1));

        // 6: asynchronous reset mid-frame
        restart_capture();
        stream(0, 0, 10);
        chk("t6_valid_before", WW'(o_window_valid), WW'(1));
        #2;
        n_rst = 1'b0;
        #1;
        chk("t6_rst_window", o_window, '0);
        chk("t6_rst_valid", WW'(o_window_valid), '0);
        chk("t6_rst_primed", WW'(o_primed), '0);
        chk("t6_rst_done", WW'(o_frame_done), '0);
        tick();
        n_rst = 1'b1;
        restart_capture();
        stream(0, 0, 15);
        drain();
        check_windows("t6_win", 0, 0, 4);
        chk("t6_done_count", WW'(done_cnt), WW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
